// File: rtl/mef_pkg.sv
// Shared types and helpers for the run detector.
// Contents:
//   estado_t  - FSM state encoding, also exported as estado_depurado
//   MODE_*    - encodings of the 2-bit mode input
//   acepta    - whether the current mode enables a run of value x
//   destino   - picks the RUN or OK state that tracks value x
package mef_pkg;

  typedef enum logic [2:0] {
    INIT = 3'b000,
    RUN0 = 3'b001,
    RUN1 = 3'b010,
    OK0  = 3'b011,
    OK1  = 3'b100
  } estado_t;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  function automatic logic acepta(input logic [1:0] mode, input logic x);
    if (x) return (mode == MODE_ONES) || (mode == MODE_BOTH);
    else   return (mode == MODE_ZEROS) || (mode == MODE_BOTH);
  endfunction

  function automatic estado_t destino(input logic x, input logic ok);
    if (ok) return x ? OK1 : OK0;
    else    return x ? RUN1 : RUN0;
  endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst - clock (rising edge), asynchronous active-high reset
//   inc      - count one event this cycle
//   clr      - synchronous clear, wins over a simultaneous inc
//   q        - count value, sticks at all-ones
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mef_detector_rachas.sv
// Moore run detector: z is high while the last RUN_LEN valid samples of a
// are equal and mode enables that value.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   en              - sample valid; a and hold are only consumed when high
//   mode            - 00 off, 01 runs of 1s, 10 runs of 0s, 11 both
//   a               - sample bit
//   hold            - freezes an active match
//   clr             - synchronous clear of det_cnt
//   z               - match flag (decoded from the state register)
//   det_pulse       - one-cycle pulse on each entry into OK0/OK1
//   run_len_o       - current run length, saturating at RUN_LEN
//   det_cnt         - saturating count of OK entries
//   estado_depurado - raw state register for debug
module mef_detector_rachas
  import mef_pkg::*;
#(
  parameter  int RUN_LEN = 3,
  parameter  int CNT_W   = 8,
  localparam int RW      = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             a,
  input  logic             hold,
  input  logic             clr,
  output logic             z,
  output logic             det_pulse,
  output logic [RW-1:0]    run_len_o,
  output logic [CNT_W-1:0] det_cnt,
  output logic [2:0]       estado_depurado
);

  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  // With single-sample runs, a change of value can jump straight to OK.
  localparam bit SOLO_UNO = (RUN_LEN == 1);

  estado_t       state_q, state_n;
  logic [RW-1:0] run_q, run_n;
  logic          pulse_q, pulse_n;
  logic          x_q;

  // Value of the run currently being tracked (meaningless in INIT).
  assign x_q = (state_q == RUN1) || (state_q == OK1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      run_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_n;
      run_q   <= run_n;
      pulse_q <= pulse_n;
    end
  end

  // Mode off dominates everything, even without a valid sample. An OK
  // state whose value is no longer enabled drops back to RUN with the run
  // length kept, so re-enabling needs one more valid sample to match.
  always_comb begin
    state_n = state_q;
    run_n   = run_q;
    pulse_n = 1'b0;
    if (mode == MODE_OFF) begin
      state_n = INIT;
      run_n   = '0;
    end else begin
      case (state_q)
        INIT: begin
          if (en) begin
            run_n   = RUN_ONE;
            state_n = destino(a, SOLO_UNO && acepta(mode, a));
          end
        end
        RUN0, RUN1: begin
          if (en) begin
            if (a == x_q) begin
              run_n   = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
              state_n = destino(x_q, (run_n == RUN_MAX) && acepta(mode, x_q));
            end else begin
              run_n   = RUN_ONE;
              state_n = destino(~x_q, SOLO_UNO && acepta(mode, ~x_q));
            end
          end
        end
        OK0, OK1: begin
          if (en && !hold) begin
            if (a == x_q) begin
              run_n   = RUN_MAX;
              state_n = destino(x_q, acepta(mode, x_q));
            end else begin
              run_n   = RUN_ONE;
              state_n = destino(~x_q, SOLO_UNO && acepta(mode, ~x_q));
            end
          end
        end
        default: begin
          state_n = INIT;
          run_n   = '0;
        end
      endcase
    end
    // Any change of state that lands in OK is a fresh detection,
    // including direct OK0<->OK1 hops.
    pulse_n = ((state_n == OK0) || (state_n == OK1)) && (state_n != state_q);
  end

  // Counting the next-state pulse keeps det_cnt in step with det_pulse.
  contador_sat #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pulse_n),
    .clr (clr),
    .q   (det_cnt)
  );

  assign z               = (state_q == OK0) || (state_q == OK1);
  assign det_pulse       = pulse_q;
  assign run_len_o       = run_q;
  assign estado_depurado = state_q;

endmodule

// File: tb/tb_mef_detector_rachas.sv
// Scoreboard bench for mef_detector_rachas (RUN_LEN=3, CNT_W=2).
// The stimulus process drives one directed vector per clock on the falling
// edge and queues the hand-computed outputs expected after the next rising
// edge; a monitor process pops and compares shortly after each rising edge,
// or immediately when the stimulus signals an asynchronous event.
module tb_mef_detector_rachas;

  typedef struct {
    logic       z;
    logic       pulse;
    logic [1:0] run;
    logic [1:0] cnt;
    logic [2:0] st;
    int         step;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       a;
  logic       hold;
  logic       clr;
  logic       z;
  logic       det_pulse;
  logic [1:0] run_len_o;
  logic [1:0] det_cnt;
  logic [2:0] estado_depurado;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;
  event sample_ev;

  mef_detector_rachas #(.RUN_LEN(3), .CNT_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .mode            (mode),
    .a               (a),
    .hold            (hold),
    .clr             (clr),
    .z               (z),
    .det_pulse       (det_pulse),
    .run_len_o       (run_len_o),
    .det_cnt         (det_cnt),
    .estado_depurado (estado_depurado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExpect(input logic ez, input logic ep, input logic [1:0] er,
                            input logic [1:0] ec, input logic [2:0] es);
    exp_t e;
    step++;
    e.z = ez; e.pulse = ep; e.run = er; e.cnt = ec; e.st = es; e.step = step;
    sb_q.push_back(e);
  endtask

  // Drive one sample cycle and queue what must be visible after the edge.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic av,
                               input logic h, input logic c,
                               input logic ez, input logic ep, input logic [1:0] er,
                               input logic [1:0] ec, input logic [2:0] es);
    @(negedge clk);
    en = e; mode = m; a = av; hold = h; clr = c;
    pushExpect(ez, ep, er, ec, es);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (z !== e.z || det_pulse !== e.pulse || run_len_o !== e.run ||
        det_cnt !== e.cnt || estado_depurado !== e.st) begin
      errors++;
      $display("[TB] FAIL step %0d: got z=%b pulse=%b run=%0d cnt=%0d st=%b, want z=%b pulse=%b run=%0d cnt=%0d st=%b",
               e.step, z, det_pulse, run_len_o, det_cnt, estado_depurado,
               e.z, e.pulse, e.run, e.cnt, e.st);
    end
  endtask

  // Monitor: compare against the oldest expectation after every rising
  // edge and after every asynchronous event flagged by the stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; a = 1'b0; hold = 1'b0; clr = 1'b0;
    #2;
    pushExpect(1'b0, 1'b0, 2'd0, 2'd0, 3'b000);
    -> sample_ev;
    @(negedge clk);
    rst = 1'b0;

    // Both values enabled: three zeros match, then the match persists.
    //            en    mode   a     hold  clr    z     pulse run   cnt   state
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd0, 3'b001);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd0, 3'b001);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 2'd3, 2'd1, 3'b011);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 2'd3, 2'd1, 3'b011);

    // Ones only: the zero match is dropped, zeros saturate without matching.
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd3, 2'd1, 3'b001);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd3, 2'd1, 3'b001);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd1, 3'b010);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd1, 3'b010);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 2'd3, 2'd2, 3'b100);

    // Gaps in en freeze the run.
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd2, 3'b001);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd2, 3'b010);
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd2, 3'b010);
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd2, 3'b010);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd2, 3'b010);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd2, 3'b010);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 2'd3, 2'd3, 3'b100);

    // Hold keeps the match against opposing samples; release breaks it.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 2'd3, 2'd3, 3'b100);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd3, 3'b001);

    // Saturated zero run, mode change without a sample, then the match
    // on the next valid sample with the counter stuck at 3.
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd3, 3'b001);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd3, 2'd3, 3'b001);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd3, 2'd3, 3'b001);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 2'd3, 2'd3, 3'b011);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd3, 3'b010);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd3, 3'b010);
    // Clear coinciding with an entry leaves zero.
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 2'd3, 2'd0, 3'b100);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 2'd3, 2'd0, 3'b100);

    // Mode off returns to INIT even without en; counter keeps its value.
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd0, 2'd0, 3'b000);
    // Zeros only.
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd0, 3'b010);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd0, 3'b010);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd3, 2'd0, 3'b010);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd0, 3'b001);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd0, 3'b001);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 2'd3, 2'd1, 3'b011);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 2'd3, 2'd0, 3'b011);

    // Ones only, build a run of two, then reset between edges.
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd0, 3'b010);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd0, 3'b010);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    pushExpect(1'b0, 1'b0, 2'd0, 2'd0, 3'b000);
    -> sample_ev;
    #3;
    rst = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd1, 2'd0, 3'b010);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 2'd2, 2'd0, 3'b010);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 2'd3, 2'd1, 3'b100);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 2'd3, 2'd1, 3'b100);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++)
      @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
